// File: rtl/ser_tx.sv
// ser_tx: parallel-load, serial-out frame transmitter.
// A word accepted on trmt is sent as: start bit (0), DATA_W data bits
// LSB-first, stop bit (1). Every bit is held for BAUD_DIV clocks.
// Shift register, bit counter and baud counter are enable flops: they
// hold their value unless the load or baud-wrap enables fire.
//
// Handshake: trmt is a level request sampled on every rising edge. It is
// accepted only while tx_busy is low (IDLE); while a frame is in flight,
// trmt and tx_data are ignored. tx_done pulses for one cycle on the edge
// that ends the frame; tx_busy is already low in that cycle.
module ser_tx #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              CLRN,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              trmt,
  output logic              TX,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int BAUD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]         state;
  logic [FRAME_W-1:0] shift_reg;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               done_q;

  logic load;
  logic baud_wrap;
  logic frame_end;

  // Enable decode: accept a request in IDLE, advance a bit on baud wrap,
  // finish the frame when the stop bit's last baud period wraps.
  always_comb begin
    load      = 1'b0;
    baud_wrap = 1'b0;
    frame_end = 1'b0;
    if (state == IDLE) begin
      load = trmt;
    end else begin
      baud_wrap = (baud_cnt == BAUD_LAST);
      frame_end = baud_wrap && (bit_cnt == BIT_LAST);
    end
  end

  // Two-state control: IDLE -> SHIFT on accept, SHIFT -> IDLE at frame end.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      state <= IDLE;
    end else if (load) begin
      state <= SHIFT;
    end else if (frame_end) begin
      state <= IDLE;
    end
  end

  // Frame shift register: loaded as {stop, data, start}, shifted right
  // with 1-fill each time a bit period ends.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= {1'b1, tx_data, 1'b0};
    end else if (baud_wrap) begin
      shift_reg <= {1'b1, shift_reg[FRAME_W-1:1]};
    end
  end

  // Baud counter: runs every clock in SHIFT, wraps at BAUD_DIV-1.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      baud_cnt <= '0;
    end else if (load) begin
      baud_cnt <= '0;
    end else if (state == SHIFT) begin
      if (baud_wrap) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Bit counter: counts finished bit periods; returns to 0 at frame end so
  // it never wraps past FRAME_W-1 even when FRAME_W is a power of two.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      bit_cnt <= '0;
    end else if (load || frame_end) begin
      bit_cnt <= '0;
    end else if (baud_wrap) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Completion pulse: high for exactly the cycle after the final wrap.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end;
    end
  end

  // TX is selected purely from flops (state and shift_reg[0]), so there is
  // no combinational path from trmt or tx_data to the line. In IDLE the
  // line is forced high regardless of the cleared shift register.
  assign TX      = (state == SHIFT) ? shift_reg[0] : 1'b1;
  assign tx_busy = (state == SHIFT);
  assign tx_done = done_q;

endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
- Parallel-load, serial-out frame transmitter.
- Accepts a DATA_W-bit word on a one-cycle request and shifts it out on a single line as start bit (0), data LSB-first, then stop bit (1). Each bit is held BAUD_DIV clocks.
- Serves as the emitting end of the lab serial link. Its state is built from the team's enable-flop style: shift register, bit counter and baud counter all hold unless enabled.

Parameters:
DATA_W, 8, number of data bits per frame (>=1)
BAUD_DIV, 4, clock cycles per transmitted bit (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
CLRN  input  1  asynchronous active-low clear (reset)
tx_data  input  DATA_W  word to transmit, sampled only when a request is accepted
trmt  input  1  transmit request, level sampled on each rising edge
TX  output  1  serial line, idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (CLRN=0, asynchronous, effective immediately without a clock edge):
  - TX=1, tx_busy=0, tx_done=0.
  - State=IDLE; shift register, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame; TX returns high at once and no tx_done is produced.
- Frame shift register width DATA_W+2 = {1'b1 stop, tx_data, 1'b0 start}. The LSB drives TX while in SHIFT.
- State machine has two states:
  - IDLE: TX=1, tx_busy=0. If trmt=1 at an edge:
    - load the shift register from tx_data;
    - clear baud_cnt and bit_cnt;
    - go to SHIFT.
    - After that edge TX=0 (start bit) and tx_busy=1.
  - SHIFT: baud_cnt increments every clock.
    - When baud_cnt==BAUD_DIV-1: baud_cnt wraps to 0, shift register shifts right by one (fill with 1), bit_cnt increments.
    - When the wrap occurs with bit_cnt==DATA_W+1 (stop bit finished): go to IDLE and set tx_done=1 for exactly one cycle.
- Timing, with acceptance edge E:
  - Bit k (k=0 start, 1..DATA_W data, DATA_W+1 stop) is driven during cycles E+1+k*BAUD_DIV through E+(k+1)*BAUD_DIV.
  - Total frame length (DATA_W+2)*BAUD_DIV cycles.
  - tx_busy falls and tx_done rises on edge E+(DATA_W+2)*BAUD_DIV.
- Request handling:
  - trmt while tx_busy=1 is ignored. tx_data changes while busy do not affect the frame in flight.
  - trmt held high continuously starts a new frame on the cycle tx_done is high, giving one idle-high cycle between frames.
  - tx_done is never asserted together with tx_busy.
- Outputs are registered; no combinational path from trmt or tx_data to TX.
- Counter widths: baud_cnt uses clog2(BAUD_DIV) bits; bit_cnt uses clog2(DATA_W+2) bits. Neither counter overflows within a frame.

Test Plan:
- Reset: hold CLRN=0 for 3 clocks -> TX=1, tx_busy=0, tx_done=0. Release, idle 5 clocks with trmt=0 -> outputs unchanged.
- Single frame, defaults (DATA_W=8, BAUD_DIV=4): pulse trmt one cycle with tx_data=8'hA5 ->
  - TX sequence, 4 clocks per bit: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy high for 40 cycles.
  - tx_done high exactly one cycle at edge 40; TX=1 afterwards.
- Ignored request: during the frame of 8'h3C, pulse trmt with tx_data=8'hFF at cycle 10 -> transmitted bits still 8'h3C. No second frame. Exactly one tx_done.
- Back-to-back: hold trmt=1 with tx_data=8'h01 then 8'h80 -> second start bit begins 1 cycle after the first tx_done. Exactly one idle-high cycle between frames. Two tx_done pulses 41 cycles apart.
- Reset mid-frame: assert CLRN=0 asynchronously at cycle 17 of a frame -> TX=1 and tx_busy=0 before the next edge. No tx_done. A subsequent trmt with 8'h5A transmits correctly.
- Parameter sweep: DATA_W=5, BAUD_DIV=2, tx_data=5'b10011 -> 14-cycle frame with bits 0,1,1,0,0,1,1. tx_done at edge 14.
